mc14500_seq: RTL and testbench

MC14500_SEQ -- requirements
Module: mc14500_seq

---
 rtl/mc14500_pkg.sv | 20 ++
 rtl/mc14500_retstack.sv | 74 +++++++
 rtl/mc14500_seq.sv | 116 +++++++++++
 tb/tb_mc14500_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc14500_pkg.sv
// mc14500_pkg
// Shared constants and types for the MC14500 program sequencer:
// opcode values seen on the ICU instruction bus, program counter width,
// return-stack depth and the sequencer state encoding.
package mc14500_pkg;

  localparam int PC_W      = 12;
  localparam int STK_DEPTH = 4;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_NOPF = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/mc14500_retstack.sv
// mc14500_retstack
// LIFO return-address stack, STK_DEPTH entries of PC_W bits.
// Pushing while full discards the oldest entry so the most recent return
// addresses survive; popping while empty leaves the stack untouched.
// Ports:
//   clk        in   flops update on the falling edge
//   rst_n      in   asynchronous active-low reset, clears depth and entries
//   push       in   store push_data as the new top of stack
//   pop        in   remove the top of stack (push wins if both asserted)
//   push_data  in   [PC_W-1:0] address to store
//   pop_data   out  [PC_W-1:0] current top of stack (0 when empty)
//   full       out  depth == STK_DEPTH
//   empty      out  depth == 0
//   depth      out  [2:0] number of valid entries
module mc14500_retstack
  import mc14500_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] pop_data,
  output logic            full,
  output logic            empty,
  output logic [2:0]      depth
);

  localparam int IDX_W = $clog2(STK_DEPTH);

  logic [PC_W-1:0] stk_q [STK_DEPTH];
  logic [PC_W-1:0] stk_d [STK_DEPTH];
  logic [2:0]      depth_q, depth_d;
  logic [2:0]      top_idx;

  // Entry 0 is the oldest; the top of stack sits at index depth-1.
  assign top_idx  = depth_q - 3'd1;
  assign full     = (depth_q == 3'(STK_DEPTH));
  assign empty    = (depth_q == 3'd0);
  assign depth    = depth_q;
  assign pop_data = empty ? '0 : stk_q[top_idx[IDX_W-1:0]];

  always_comb begin
    stk_d   = stk_q;
    depth_d = depth_q;
    if (push) begin
      if (full) begin
        // Overflow: slide everything toward the bottom, dropping entry 0.
        for (int i = 0; i < STK_DEPTH - 1; i++) begin
          stk_d[i] = stk_q[i+1];
        end
        stk_d[STK_DEPTH-1] = push_data;
      end else begin
        stk_d[depth_q[IDX_W-1:0]] = push_data;
        depth_d = depth_q + 3'd1;
      end
    end else if (pop && !empty) begin
      depth_d = depth_q - 3'd1;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= 3'd0;
      for (int i = 0; i < STK_DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      depth_q <= depth_d;
      stk_q   <= stk_d;
    end
  end

endmodule

// File: rtl/mc14500_seq.sv
// mc14500_seq
// Program sequencer for an MC14500 ICU: holds the program counter, feeds
// the opcode to the ICU with zero fetch latency, and performs JMP/RTN
// through a 4-entry return stack. NOPF halts the sequencer until GO.
// Ports:
//   X2         in   system clock; all flops update on its falling edge
//   RSTb       in   asynchronous active-low reset
//   PROG_DATA  in   [15:0] program word at PROG_ADDR (opcode, operand)
//   JMP/RTN    in   ICU decodes for the executing instruction
//   FLAG_F     in   ICU NOPF decode, treated as halt request
//   GO         in   resume request while halted
//   PROG_ADDR  out  [11:0] program counter
//   I          out  [3:0] opcode to the ICU (NOPF while halted)
//   IO_ADDR    out  [7:0] I/O select, low byte of the program word
//   HALTED     out  sequencer is halted
//   STK_ERR    out  sticky return-stack overflow/underflow flag
//   SP         out  [2:0] return-stack depth
module mc14500_seq
  import mc14500_pkg::*;
(
  input  logic            X2,
  input  logic            RSTb,
  input  logic [15:0]     PROG_DATA,
  input  logic            JMP,
  input  logic            RTN,
  input  logic            FLAG_F,
  input  logic            GO,
  output logic [PC_W-1:0] PROG_ADDR,
  output logic [3:0]      I,
  output logic [7:0]      IO_ADDR,
  output logic            HALTED,
  output logic            STK_ERR,
  output logic [2:0]      SP
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            stk_err_q, stk_err_d;

  logic            stk_push, stk_pop;
  logic [PC_W-1:0] stk_top;
  logic            stk_full, stk_empty;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + PC_W'(1);

  mc14500_retstack u_retstack (
    .clk       (X2),
    .rst_n     (RSTb),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .pop_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .depth     (SP)
  );

  // Controls are sampled on the falling edge while PROG_DATA still holds
  // the word the ICU latched on the preceding rising edge. Priority is
  // JMP > RTN > FLAG_F; the halt state ignores all three.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stk_err_d = stk_err_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (JMP) begin
          pc_d     = PROG_DATA[PC_W-1:0];
          stk_push = 1'b1;
          if (stk_full) stk_err_d = 1'b1;
        end else if (RTN) begin
          if (stk_empty) begin
            pc_d      = pc_inc;
            stk_err_d = 1'b1;
          end else begin
            pc_d    = stk_top;
            stk_pop = 1'b1;
          end
        end else if (FLAG_F) begin
          state_d = ST_HALT;
        end else begin
          pc_d = pc_inc;
        end
      end
      ST_HALT: begin
        if (GO) begin
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(negedge X2 or negedge RSTb) begin
    if (!RSTb) begin
      state_q   <= ST_RUN;
      pc_q      <= '0;
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      stk_err_q <= stk_err_d;
    end
  end

  assign HALTED    = (state_q == ST_HALT);
  assign I         = HALTED ? OP_NOPF : PROG_DATA[15:12];
  assign IO_ADDR   = PROG_DATA[7:0];
  assign PROG_ADDR = pc_q;
  assign STK_ERR   = stk_err_q;

endmodule

// File: tb/tb_mc14500_seq.sv
// tb_mc14500_seq
// Self-checking bench for mc14500_seq: a queue-based reference model of the
// sequencer is stepped on every falling X2 and compared with all outputs,
// with directed scenarios pinned by literal expectations plus a random run.
module tb_mc14500_seq;

  logic        X2 = 1'b0;
  logic        RSTb = 1'b0;
  logic [15:0] PROG_DATA = 16'h0;
  logic        JMP = 1'b0, RTN = 1'b0, FLAG_F = 1'b0, GO = 1'b0;
  logic [11:0] PROG_ADDR;
  logic [3:0]  I;
  logic [7:0]  IO_ADDR;
  logic        HALTED, STK_ERR;
  logic [2:0]  SP;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [11:0] m_pc;
  bit          m_halt;
  bit          m_err;
  logic [11:0] m_stk [$];

  mc14500_seq dut (
    .X2        (X2),
    .RSTb      (RSTb),
    .PROG_DATA (PROG_DATA),
    .JMP       (JMP),
    .RTN       (RTN),
    .FLAG_F    (FLAG_F),
    .GO        (GO),
    .PROG_ADDR (PROG_ADDR),
    .I         (I),
    .IO_ADDR   (IO_ADDR),
    .HALTED    (HALTED),
    .STK_ERR   (STK_ERR),
    .SP        (SP)
  );

  always #5 X2 = ~X2;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the reference model.
  task automatic checkOutput();
    checkVal("PROG_ADDR", 32'(PROG_ADDR), 32'(m_pc));
    checkVal("SP", 32'(SP), 32'(m_stk.size()));
    checkVal("HALTED", 32'(HALTED), 32'(m_halt));
    checkVal("STK_ERR", 32'(STK_ERR), 32'(m_err));
    checkVal("I", 32'(I), m_halt ? 32'hF : 32'(PROG_DATA[15:12]));
    checkVal("IO_ADDR", 32'(IO_ADDR), 32'(PROG_DATA[7:0]));
  endtask

  function automatic void modelReset();
    m_pc   = 12'h000;
    m_halt = 1'b0;
    m_err  = 1'b0;
    m_stk.delete();
  endfunction

  // One falling-edge step of the sequencer as described behaviourally.
  function automatic void modelStep();
    logic [11:0] discard;
    if (m_halt) begin
      if (GO) begin
        m_pc   = m_pc + 12'd1;
        m_halt = 1'b0;
      end
    end else if (JMP) begin
      if (m_stk.size() == 4) begin
        discard = m_stk.pop_front();
        m_err   = 1'b1;
      end
      m_stk.push_back(m_pc + 12'd1);
      m_pc = PROG_DATA[11:0];
    end else if (RTN) begin
      if (m_stk.size() == 0) begin
        m_pc  = m_pc + 12'd1;
        m_err = 1'b1;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (FLAG_F) begin
      m_halt = 1'b1;
    end else begin
      m_pc = m_pc + 12'd1;
    end
  endfunction

  // Drive one instruction between edges, check combinational outputs,
  // then let the falling edge act and check the registered result.
  task automatic applyStimulus(input logic [15:0] data, input logic j, input logic r,
                               input logic f, input logic g);
    @(posedge X2);
    PROG_DATA = data;
    JMP = j; RTN = r; FLAG_F = f; GO = g;
    #1 checkOutput();
    @(negedge X2);
    modelStep();
    #1 checkOutput();
  endtask

  // Reset asserted asynchronously while X2 is low; outputs must clear at once.
  task automatic doReset();
    @(negedge X2);
    #2;
    JMP = 1'b0; RTN = 1'b0; FLAG_F = 1'b0; GO = 1'b0;
    RSTb = 1'b0;
    #1;
    modelReset();
    checkOutput();
    checkVal("rst_pc", 32'(PROG_ADDR), 32'h0);
    checkVal("rst_sp", 32'(SP), 32'h0);
    checkVal("rst_halted", 32'(HALTED), 32'h0);
    checkVal("rst_err", 32'(STK_ERR), 32'h0);
    #1 RSTb = 1'b1;
  endtask

  task automatic plain(input int n);
    for (int k = 0; k < n; k++) applyStimulus(16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [11:0] exp_ret [4];
    int          r;
    exp_ret = '{12'h401, 12'h301, 12'h201, 12'h101};
    modelReset();

    // Straight-line fetch from address 0
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
      checkVal("fetch_seq", 32'(PROG_ADDR), 32'(k + 1));
    end

    // Call and return
    doReset();
    plain(16);
    checkVal("call_at", 32'(PROG_ADDR), 32'h010);
    applyStimulus(16'hC200, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("call_pc", 32'(PROG_ADDR), 32'h200);
    checkVal("call_sp", 32'(SP), 32'h1);
    plain(3);
    applyStimulus(16'hD000, 1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("ret_pc", 32'(PROG_ADDR), 32'h011);
    checkVal("ret_sp", 32'(SP), 32'h0);

    // Five nested calls overflow the stack
    doReset();
    for (int k = 1; k <= 5; k++) applyStimulus({4'hC, 4'(k), 8'h00}, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("ovf_sp", 32'(SP), 32'h4);
    checkVal("ovf_err", 32'(STK_ERR), 32'h1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(16'hD000, 1'b0, 1'b1, 1'b0, 1'b0);
      checkVal("ovf_ret", 32'(PROG_ADDR), 32'(exp_ret[k]));
    end
    checkVal("ovf_sp_end", 32'(SP), 32'h0);

    // Return with empty stack
    doReset();
    plain(48);
    applyStimulus(16'hD000, 1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("udf_pc", 32'(PROG_ADDR), 32'h031);
    checkVal("udf_err", 32'(STK_ERR), 32'h1);
    checkVal("udf_sp", 32'(SP), 32'h0);

    // Halt, ignored controls, resume
    doReset();
    plain(64);
    applyStimulus(16'hF000, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("halt_flag", 32'(HALTED), 32'h1);
    checkVal("halt_pc", 32'(PROG_ADDR), 32'h040);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      checkVal("halt_hold", 32'(PROG_ADDR), 32'h040);
      checkVal("halt_i", 32'(I), 32'hF);
    end
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("go_pc", 32'(PROG_ADDR), 32'h041);
    checkVal("go_halted", 32'(HALTED), 32'h0);

    // PC wrap
    doReset();
    applyStimulus(16'hCFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("wrap_at", 32'(PROG_ADDR), 32'hFFF);
    plain(1);
    checkVal("wrap_pc", 32'(PROG_ADDR), 32'h000);

    // Reset mid-halt with two return addresses pending
    doReset();
    applyStimulus(16'hC100, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hC200, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hF000, 1'b0, 1'b0, 1'b1, 1'b0);
    plain(3);
    checkVal("pre_rst_sp", 32'(SP), 32'h2);
    checkVal("pre_rst_halted", 32'(HALTED), 32'h1);
    doReset();
    plain(2);
    checkVal("post_rst_pc", 32'(PROG_ADDR), 32'h002);

    // Randomized run, including illegal multi-control combinations
    doReset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      r = int'($urandom_range(0, 99));
      applyStimulus(16'($urandom),
                    (r < 12) || (r >= 95),
                    (r >= 12 && r < 26) || (r >= 93),
                    (r >= 26 && r < 31) || (r >= 90),
                    ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
